multicycle_main_control: RTL
============================

Name: multicycle_main_control

Overview:
Main control FSM for the multicycle CPU. It sequences fetch, decode, execute, memory and writeback, and drives all datapath enables and mux selects. It exports the 4-bit state code and pc_write_uncond to the PC-write controller, which qualifies conditional branches in state 7. Memory accesses wait on a ready handshake, and a watchdog aborts stalled accesses.

Parameters:
MEM_TIMEOUT, 15, max cycles to wait for mem_ready in a memory state before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26], valid from state 1 onward
mem_ready  in  1  memory completes the current read/write this cycle
state  out  4  current state code
pc_write_uncond  out  1  unconditional PC write
ir_write  out  1  latch instruction register
mem_read  out  1  memory read request
mem_write  out  1  memory write request
i_or_d  out  1  0 = PC address, 1 = ALUOut address
reg_write  out  1  register file write
reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = imm<<2
alu_op  out  2  0 = add, 1 = sub (compare), 2 = funct, 3 = opcode-immediate
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
mem_fault  out  1  sticky; set on watchdog abort, cleared only by reset
illegal_op  out  1  one-cycle pulse in state 1 for an undefined opcode

Behaviour:
- Opcodes: RTYPE 000000, ADDI 000001, ANDI 000010, ORI 000011, LW 000100, SW 000101, J 000110, JAL 000111, BGT 001000, BLT 001001, BEQ 001010, BNE 001011. All others are illegal.
- States:
  - 0 FETCH: mem_read=1, i_or_d=0. On mem_ready: ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0, pc_write_uncond=1, then go to 1. Otherwise hold.
  - 1 DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target into ALUOut). Next state:
    - LW/SW -> 2
    - RTYPE -> 6
    - ADDI/ANDI/ORI -> 10
    - branches -> 7
    - J/JAL -> 9
    - illegal -> 0 with illegal_op=1
  - 2 ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. LW -> 3, SW -> 5.
  - 3 MEM_RD: mem_read=1, i_or_d=1. Go to 4 on mem_ready.
  - 4 LOAD_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Go to 0.
  - 5 MEM_WR: mem_write=1, i_or_d=1. Go to 0 on mem_ready.
  - 6 R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Go to 8.
  - 7 BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1, pc_write_uncond=0. The external PC-write controller decides the write. Go to 0.
  - 8 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to 0.
  - 9 JUMP: pc_source=2, pc_write_uncond=1. For JAL also reg_write=1, reg_dst=2, mem_to_reg=2; PC still holds PC+4 this cycle, so r31 gets the return address. Go to 0.
  - 10 I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=3. Go to 11.
  - 11 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to 0.
  - 12-15: unreachable. If entered, go to 0 with all outputs at default.
- Outputs are Moore, decoded from the state register, except these, which are combinational on mem_ready in state 0: ir_write, pc_write_uncond, alu_src_b=1, alu_op=0.
- Default for every unlisted output is 0.
- Watchdog: an 8-bit counter clears on entry to states 0, 3 and 5 and increments each cycle mem_ready=0 in those states. When the counter reaches MEM_TIMEOUT with mem_ready still 0:
  - deassert the request
  - set mem_fault
  - go to 0 (from 3/5) or stay in 0 with the counter cleared (from 0)
  - mem_ready arriving on the timeout cycle wins: normal completion, no fault.
- Reset (asynchronous, any time, including mid-access): state=0, watchdog counter=0, mem_fault=0. All outputs go to default immediately, except mem_read=1, which is the state-0 Moore output.
- Instruction latency with zero-wait memory:
  - 3 cycles: J, JAL, branches
  - 4 cycles: RTYPE, ADDI/ANDI/ORI, SW
  - 5 cycles: LW
  - add one cycle per wait cycle in states 0, 3 and 5.

Test Plan:
- Reset asserted mid state 3, deasserted; mem_ready=1 constantly -> state=0 immediately; next edge ir_write=1, pc_write_uncond=1; state sequence 0,1,...; mem_fault=0.
- LW opcode 000100, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in 4 with mem_to_reg=1.
- BEQ 001010 -> states 0,1,7,0; in 7 pc_write_uncond=0, pc_source=1, alu_op=1.
- JAL 000111 -> states 0,1,9,0; in 9 pc_write_uncond=1, reg_dst=2, mem_to_reg=2, reg_write=1.
- SW with mem_ready low for 3 cycles in state 5 -> state 5 held 4 cycles, mem_write=1 throughout, then 0; SW with mem_ready never high, MEM_TIMEOUT=15 -> exit to 0 after 15 wait cycles, mem_fault=1 sticky.
- Opcode 111111 -> states 0,1,0; illegal_op=1 for exactly the one state-1 cycle, no reg_write or PC write.

Source files
------------

// File: rtl/multicycle_main_control.sv
// ============================================================================
//  Module   : multicycle_main_control
//  Purpose  : Main control FSM of the multicycle CPU, with a memory watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_main_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic [3:0] state,
  output logic       pc_write_uncond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       mem_fault,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_ADDR    = 4'd2,
    S_MEM_RD  = 4'd3,
    S_LOAD_WB = 4'd4,
    S_MEM_WR  = 4'd5,
    S_R_EXEC  = 4'd6,
    S_BRANCH  = 4'd7,
    S_R_WB    = 4'd8,
    S_JUMP    = 4'd9,
    S_I_EXEC  = 4'd10,
    S_I_WB    = 4'd11
  } state_e;

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_ADDI  = 6'b000001;
  localparam logic [5:0] C_OP_ANDI  = 6'b000010;
  localparam logic [5:0] C_OP_ORI   = 6'b000011;
  localparam logic [5:0] C_OP_LW    = 6'b000100;
  localparam logic [5:0] C_OP_SW    = 6'b000101;
  localparam logic [5:0] C_OP_J     = 6'b000110;
  localparam logic [5:0] C_OP_JAL   = 6'b000111;
  localparam logic [5:0] C_OP_BGT   = 6'b001000;
  localparam logic [5:0] C_OP_BLT   = 6'b001001;
  localparam logic [5:0] C_OP_BEQ   = 6'b001010;
  localparam logic [5:0] C_OP_BNE   = 6'b001011;

  localparam logic [7:0] C_TIMEOUT = 8'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic       fault_q, fault_d;
  logic       w_in_mem;
  logic       w_expire;
  logic       w_fetch_done;

  assign w_in_mem = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

  // A ready arriving on the timeout cycle takes priority over the abort.
  assign w_expire = w_in_mem && !mem_ready && (wd_q == C_TIMEOUT);

  // Reset forces the mem_ready-dependent fetch outputs to their defaults.
  assign w_fetch_done = mem_ready && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      wd_q    <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    pc_write_uncond = 1'b0;
    ir_write        = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    i_or_d          = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 2'd0;
    mem_to_reg      = 2'd0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'd0;
    alu_op          = 2'd0;
    pc_source       = 2'd0;
    illegal_op      = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = !w_expire;
        if (w_fetch_done) begin
          ir_write        = 1'b1;
          alu_src_b       = 2'd1;
          pc_write_uncond = 1'b1;
          state_d         = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          C_OP_LW, C_OP_SW:                  state_d = S_ADDR;
          C_OP_RTYPE:                        state_d = S_R_EXEC;
          C_OP_ADDI, C_OP_ANDI, C_OP_ORI:    state_d = S_I_EXEC;
          C_OP_BGT, C_OP_BLT, C_OP_BEQ,
          C_OP_BNE:                          state_d = S_BRANCH;
          C_OP_J, C_OP_JAL:                  state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end

      S_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_read = !w_expire;
        i_or_d   = 1'b1;
        if (mem_ready)     state_d = S_LOAD_WB;
        else if (w_expire) state_d = S_FETCH;
      end

      S_LOAD_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = !w_expire;
        i_or_d    = 1'b1;
        if (mem_ready || w_expire) state_d = S_FETCH;
      end

      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_R_WB;
      end

      S_BRANCH: begin
        // The PC-write controller qualifies the branch from the state code.
        alu_src_a = 1'b1;
        alu_op    = 2'd1;
        pc_source = 2'd1;
        state_d   = S_FETCH;
      end

      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 2'd1;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_source       = 2'd2;
        pc_write_uncond = 1'b1;
        if (opcode == C_OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = S_FETCH;
      end

      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_op    = 2'd3;
        state_d   = S_I_WB;
      end

      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  // Watchdog restarts on every state change and after an abort in FETCH.
  always_comb begin
    wd_d = wd_q;
    if ((state_d != state_q) || w_expire)
      wd_d = 8'd0;
    else if (w_in_mem && !mem_ready)
      wd_d = wd_q + 8'd1;
  end

  assign fault_d   = fault_q | w_expire;
  assign state     = state_q;
  assign mem_fault = fault_q;

endmodule

`default_nettype wire
